// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
//   state_t       : FSM encoding (IDLE=0, BUSY=1, RESP=2)
//   owner_t       : requester encoding (OWN_I=0 fetch, OWN_D=1 data)
//   WORD_SIZE_DEF : default data/address width
//   CNT_W         : width of the access-latency down-counter (MEM_LATENCY <= 15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int WORD_SIZE_DEF = 16;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between the fetch and data requesters.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : data always wins a contested cycle
//   defined   : a contested cycle goes to the requester that lost the last
//               contested cycle (tracked by the parent in last_owner)
// Ports:
//   i_read               fetch request
//   d_read, d_write      data requests (both high is served as a write upstream)
//   last_owner           (round-robin only) winner of the previous contest
//   req_any              at least one request is pending
//   grant_owner          selected owner
//   contested            (round-robin only) both requesters are active
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   i_read,
  input  logic   d_read,
  input  logic   d_write,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t last_owner,
  output logic   contested,
`endif
  output logic   req_any,
  output owner_t grant_owner
);

  logic d_req;

  always_comb begin
    d_req       = d_read | d_write;
    req_any     = i_read | d_req;
    grant_owner = d_req ? OWN_D : OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
    contested = i_read & d_req;
    if (contested) begin
      grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory. An instruction-fetch port
// (read only) and a data port (read/write) share one memory. Each access
// takes MEM_LATENCY BUSY cycles followed by one RESP cycle that pulses the
// owner's ready; requests seen outside IDLE are not queued.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating priority on
// contested cycles; otherwise fixed data priority).
// Parameters: WORD_SIZE (data/address width), MEM_LATENCY (1..15).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_read, i_addr               fetch request and address
//   i_data, i_ready              fetch read data and completion pulse
//   d_read, d_write              data read / write requests
//   d_addr, d_wdata              data address and write data
//   d_rdata, d_ready             data read result and completion pulse
//   m_read, m_write              memory strobes
//   m_addr, m_wdata, m_rdata     memory address, write data, read data
//   busy                         high whenever the FSM is not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic             req_any;
  owner_t           grant_owner;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;
  logic   contested;
`endif

  mem_arb_grant u_grant (
    .i_read      (i_read),
    .d_read      (d_read),
    .d_write     (d_write),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner  (last_owner),
    .contested   (contested),
`endif
    .req_any     (req_any),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= OWN_I;
      cnt     <= '0;
      busy    <= 1'b0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      // Reset to fetch so the first contest goes to data.
      last_owner <= OWN_I;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state <= BUSY;
            busy  <= 1'b1;
            owner <= grant_owner;
            cnt   <= CNT_LOAD;
            if (grant_owner == OWN_D) begin
              // d_write wins over d_read so an illegal read+write is a write.
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_write <= d_write;
              m_read  <= ~d_write;
            end else begin
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_write <= 1'b0;
              m_read  <= 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (contested) begin
              last_owner <= grant_owner;
            end
`endif
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state   <= RESP;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            // m_write still holds the access direction in its last BUSY cycle.
            if (owner == OWN_D) begin
              d_ready <= 1'b1;
              if (!m_write) begin
                d_rdata <= m_rdata;
              end
            end else begin
              i_ready <= 1'b1;
              i_data  <= m_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          m_read  <= 1'b0;
          m_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read, d_read, d_write;
  logic [W-1:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [W-1:0] i_data, d_rdata, m_addr, m_wdata;
  logic         i_ready, d_ready, m_read, m_write, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_read  (i_read),
    .i_addr  (i_addr),
    .i_data  (i_data),
    .i_ready (i_ready),
    .d_read  (d_read),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_read  (m_read),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  typedef struct {
    logic         i_read, d_read, d_write;
    logic [W-1:0] i_addr, d_addr, d_wdata, m_rdata;
    logic         exp_rd, exp_wr;
    logic [W-1:0] exp_addr;
    logic         chk_wd;
    logic [W-1:0] exp_wd;
    logic         exp_ir, exp_dr;
    logic [W-1:0] exp_idata, exp_drdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h, expected %04h", name, act, exp);
    end
  endtask

  // Call with the request already driven in an IDLE cycle; returns #1 after
  // the edge that starts the RESP cycle (cycle 3 for MEM_LATENCY=2).
  task automatic access(input string tag, input logic exp_rd, input logic exp_wr,
                        input logic [W-1:0] exp_addr, input logic chk_wd,
                        input logic [W-1:0] exp_wd, input logic exp_ir,
                        input logic exp_dr);
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      chk1({tag, ".m_read"},  m_read,  exp_rd);
      chk1({tag, ".m_write"}, m_write, exp_wr);
      chkw({tag, ".m_addr"},  m_addr,  exp_addr);
      if (chk_wd) chkw({tag, ".m_wdata"}, m_wdata, exp_wd);
      chk1({tag, ".busy"},    busy,    1'b1);
      chk1({tag, ".i_ready_early"}, i_ready, 1'b0);
      chk1({tag, ".d_ready_early"}, d_ready, 1'b0);
    end
    @(posedge clk); #1;
    chk1({tag, ".m_read_resp"},  m_read,  1'b0);
    chk1({tag, ".m_write_resp"}, m_write, 1'b0);
    chk1({tag, ".i_ready"},      i_ready, exp_ir);
    chk1({tag, ".d_ready"},      d_ready, exp_dr);
    chk1({tag, ".busy_resp"},    busy,    1'b1);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk1({tag, ".busy_idle"},    busy,    1'b0);
    chk1({tag, ".i_ready_idle"}, i_ready, 1'b0);
    chk1({tag, ".d_ready_idle"}, d_ready, 1'b0);
    chk1({tag, ".m_read_idle"},  m_read,  1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic         first_d;
    logic [W-1:0] a_first, a_second;

    //            ir dr dw i_addr    d_addr    d_wdata   m_rdata   rd wr addr     cw wd        ir dr i_data    d_rdata
    vecs[0] = '{1'b1,1'b0,1'b0,16'h0010,16'h0000,16'h0000,16'hA5A5,1'b1,1'b0,16'h0010,1'b0,16'h0000,1'b1,1'b0,16'hA5A5,16'h0000};
    vecs[1] = '{1'b0,1'b1,1'b0,16'h0000,16'h0200,16'h0000,16'h5A5A,1'b1,1'b0,16'h0200,1'b0,16'h0000,1'b0,1'b1,16'hA5A5,16'h5A5A};
    vecs[2] = '{1'b0,1'b0,1'b1,16'h0000,16'h0300,16'h1234,16'hFFFF,1'b0,1'b1,16'h0300,1'b1,16'h1234,1'b0,1'b1,16'hA5A5,16'h5A5A};
    vecs[3] = '{1'b0,1'b1,1'b1,16'h0000,16'h0400,16'hCAFE,16'h1111,1'b0,1'b1,16'h0400,1'b1,16'hCAFE,1'b0,1'b1,16'hA5A5,16'h5A5A};
    vecs[4] = '{1'b0,1'b1,1'b0,16'h0000,16'hFFFF,16'h0000,16'h0000,1'b1,1'b0,16'hFFFF,1'b0,16'h0000,1'b0,1'b1,16'hA5A5,16'h0000};
    vecs[5] = '{1'b1,1'b0,1'b0,16'h0FFE,16'h0000,16'h0000,16'hFFFF,1'b1,1'b0,16'h0FFE,1'b0,16'h0000,1'b1,1'b0,16'hFFFF,16'h0000};

    reset_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.m_read", m_read, 1'b0);
    chk1("rst.m_write", m_write, 1'b0);
    chk1("rst.i_ready", i_ready, 1'b0);
    chk1("rst.d_ready", d_ready, 1'b0);
    chkw("rst.i_data", i_data, 16'h0000);
    chkw("rst.d_rdata", d_rdata, 16'h0000);
    chkw("rst.m_addr", m_addr, 16'h0000);
    chkw("rst.m_wdata", m_wdata, 16'h0000);
    reset_n = 1'b1;
    idle_cycle("post_rst");

    // Single-requester accesses from the vector table.
    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      i_read  = vecs[v].i_read;
      d_read  = vecs[v].d_read;
      d_write = vecs[v].d_write;
      i_addr  = vecs[v].i_addr;
      d_addr  = vecs[v].d_addr;
      d_wdata = vecs[v].d_wdata;
      m_rdata = vecs[v].m_rdata;
      access(tag, vecs[v].exp_rd, vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].chk_wd,
             vecs[v].exp_wd, vecs[v].exp_ir, vecs[v].exp_dr);
      chkw({tag, ".i_data"},  i_data,  vecs[v].exp_idata);
      chkw({tag, ".d_rdata"}, d_rdata, vecs[v].exp_drdata);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      idle_cycle(tag);
    end

    // Reset asserted during the second BUSY cycle.
    i_read = 1'b1; i_addr = 16'h0123; m_rdata = 16'hABCD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("rstmid.m_read_before", m_read, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("rstmid.m_read", m_read, 1'b0);
    chk1("rstmid.busy", busy, 1'b0);
    chkw("rstmid.m_addr", m_addr, 16'h0000);
    chkw("rstmid.i_data", i_data, 16'h0000);
    chkw("rstmid.d_rdata", d_rdata, 16'h0000);
    i_read = 1'b0;
    @(posedge clk); #1;
    chk1("rstmid.i_ready", i_ready, 1'b0);
    chk1("rstmid.busy_held", busy, 1'b0);
    reset_n = 1'b1;
    d_read = 1'b1; d_addr = 16'h0700; m_rdata = 16'h9999;
    access("rstmid_new", 1'b1, 1'b0, 16'h0700, 1'b0, 16'h0000, 1'b0, 1'b1);
    chkw("rstmid_new.d_rdata", d_rdata, 16'h9999);
    d_read = 1'b0;
    idle_cycle("rstmid_new");

    // Request dropped after grant; a request raised during BUSY waits for IDLE.
    d_read = 1'b1; d_addr = 16'h0800; m_rdata = 16'h4242;
    @(posedge clk); #1;
    d_read = 1'b0;
    chk1("drop.m_read_c1", m_read, 1'b1);
    chkw("drop.m_addr_c1", m_addr, 16'h0800);
    @(posedge clk); #1;
    chk1("drop.m_read_c2", m_read, 1'b1);
    d_read = 1'b1; d_addr = 16'h0900;
    @(posedge clk); #1;
    chk1("drop.d_ready", d_ready, 1'b1);
    chkw("drop.d_rdata", d_rdata, 16'h4242);
    chk1("drop.m_read_c3", m_read, 1'b0);
    @(posedge clk); #1;
    chk1("drop.busy_c4", busy, 1'b0);
    chk1("drop.m_read_c4", m_read, 1'b0);
    m_rdata = 16'h0F0F;
    access("late", 1'b1, 1'b0, 16'h0900, 1'b0, 16'h0000, 1'b0, 1'b1);
    chkw("late.d_rdata", d_rdata, 16'h0F0F);
    d_read = 1'b0;
    idle_cycle("late");

    // First contest: data wins in both priority modes; fetch is served next.
    i_read = 1'b1; i_addr = 16'h0044;
    d_read = 1'b1; d_addr = 16'h0200; m_rdata = 16'h3C3C;
    access("ctA1", 1'b1, 1'b0, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b1);
    chkw("ctA1.d_rdata", d_rdata, 16'h3C3C);
    d_read = 1'b0; m_rdata = 16'h7E7E;
    @(posedge clk); #1;
    chk1("ctA.busy_c4", busy, 1'b0);
    access("ctA2", 1'b1, 1'b0, 16'h0044, 1'b0, 16'h0000, 1'b1, 1'b0);
    chkw("ctA2.i_data", i_data, 16'h7E7E);
    i_read = 1'b0;
    idle_cycle("ctA2");

    // Second contest: round-robin serves fetch first, fixed priority data.
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    a_first  = first_d ? 16'h0600 : 16'h0066;
    a_second = first_d ? 16'h0066 : 16'h0600;
    i_read = 1'b1; i_addr = 16'h0066;
    d_read = 1'b1; d_addr = 16'h0600; m_rdata = 16'h1357;
    access("ctB1", 1'b1, 1'b0, a_first, 1'b0, 16'h0000, ~first_d, first_d);
    chkw("ctB1.i_data",  i_data,  first_d ? 16'h7E7E : 16'h1357);
    chkw("ctB1.d_rdata", d_rdata, first_d ? 16'h1357 : 16'h3C3C);
    if (first_d) d_read = 1'b0;
    else         i_read = 1'b0;
    m_rdata = 16'h2468;
    @(posedge clk); #1;
    chk1("ctB.busy_c4", busy, 1'b0);
    access("ctB2", 1'b1, 1'b0, a_second, 1'b0, 16'h0000, first_d, ~first_d);
    chkw("ctB2.i_data",  i_data,  first_d ? 16'h2468 : 16'h1357);
    chkw("ctB2.d_rdata", d_rdata, first_d ? 16'h1357 : 16'h2468);
    i_read = 1'b0; d_read = 1'b0;
    idle_cycle("ctB2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
